// File: rtl/button_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// button_debouncer_pkg : shared defaults and counter-width helper
// Revision 1.0
// ============================================================================
package button_debouncer_pkg;

   localparam int DEFAULT_BTN_COUNT     = 7;
   localparam int DEFAULT_STABLE_CYCLES = 500000;
   localparam int DEFAULT_REPEAT_DELAY  = 25000000;
   localparam int DEFAULT_REPEAT_PERIOD = 5000000;

   // Bits needed to hold 0..count, never narrower than one bit.
   function automatic int cnt_width(input int count);
      int w;
      w = $clog2(count + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer_if.sv
`default_nettype none
// ============================================================================
// button_debouncer_if : raw button inputs and debounced outputs
// Revision 1.0
// ============================================================================
interface button_debouncer_if
   import button_debouncer_pkg::*;
#(
   parameter int BTN_COUNT = DEFAULT_BTN_COUNT
);
   logic [BTN_COUNT-1:0] btn;
   logic [BTN_COUNT-1:0] level;
   logic [BTN_COUNT-1:0] trigger;
   logic [BTN_COUNT-1:0] released;

   modport master (output btn, input level, input trigger, input released);
   modport slave  (input btn, output level, output trigger, output released);
endinterface
`default_nettype wire

// File: rtl/button_debouncer_channel.sv
`default_nettype none
// ============================================================================
// debounce_channel : one-bit synchroniser, stability counter and edge strobes
// Optional auto-repeat under BUTTON_DEBOUNCER_AUTOREPEAT_EN.  Revision 1.0
// ============================================================================
module debounce_channel
   import button_debouncer_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
`endif
) (
   input  wire  clk,
   input  wire  reset,
   input  wire  btn_i,
   output logic level_o,
   output logic trigger_o,
   output logic released_o
);

   localparam int            CW          = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

   logic          s1_q, s_q;
   logic          level_q, level_d;
   logic          trigger_q, trigger_d;
   logic          released_q, released_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rpt_fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q       <= 1'b0;
         s_q        <= 1'b0;
         level_q    <= 1'b0;
         trigger_q  <= 1'b0;
         released_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_q       <= btn_i;
         s_q        <= s1_q;
         level_q    <= level_d;
         trigger_q  <= trigger_d;
         released_q <= released_d;
         cnt_q      <= cnt_d;
      end
   end

   // Any cycle where the synchronised input agrees with level restarts the count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (s_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == STABLE_LAST) begin
         level_d = s_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      trigger_d  = (level_d & ~level_q) | rpt_fire;
      released_d = ~level_d & level_q;
   end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = cnt_width(RPT_MAX);
   localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic          rpt_period_q, rpt_period_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         rpt_cnt_q    <= '0;
         rpt_period_q <= 1'b0;
      end else begin
         rpt_cnt_q    <= rpt_cnt_d;
         rpt_period_q <= rpt_period_d;
      end
   end

   // rpt_period_q selects the long first delay (0) or the steady repeat period (1).
   always_comb begin
      rpt_cnt_d    = rpt_cnt_q;
      rpt_period_d = rpt_period_q;
      rpt_fire     = 1'b0;
      if (!(level_q && s_q)) begin
         rpt_cnt_d    = '0;
         rpt_period_d = 1'b0;
      end else if (rpt_cnt_q == (rpt_period_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
         rpt_fire     = 1'b1;
         rpt_cnt_d    = '0;
         rpt_period_d = 1'b1;
      end else begin
         rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   assign level_o    = level_q;
   assign trigger_o  = trigger_q;
   assign released_o = released_q;

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// button_debouncer : BTN_COUNT independent debounce channels with press/release
// strobes; auto-repeat built when BUTTON_DEBOUNCER_AUTOREPEAT_EN is defined. Rev 1.0
// ============================================================================
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int BTN_COUNT     = DEFAULT_BTN_COUNT,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
   input  wire               clk,
   input  wire               reset,
   button_debouncer_if.slave bus
);

   generate
      for (genvar i = 0; i < BTN_COUNT; i++) begin : g_chan
         debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES)
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
         ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .btn_i      (bus.btn[i]),
            .level_o    (bus.level[i]),
            .trigger_o  (bus.trigger[i]),
            .released_o (bus.released[i])
         );
      end
   endgenerate

`ifndef BUTTON_DEBOUNCER_AUTOREPEAT_EN
   // Repeat timing is accepted for interface compatibility but has no effect here.
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// tb_button_debouncer : table-driven check of the 3-button, 4-cycle debouncer
// Revision 1.0
// ============================================================================
module tb_button_debouncer;

   localparam int N      = 3;
   localparam int STABLE = 4;
   localparam int RDELAY = 20;
   localparam int RPER   = 8;

   typedef struct {
      logic         rst;
      logic [N-1:0] btn;
      logic [N-1:0] lvl;
      logic [N-1:0] trg;
      logic [N-1:0] rel;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];

   button_debouncer_if #(.BTN_COUNT(N)) bus ();

   button_debouncer #(
      .BTN_COUNT     (N),
      .STABLE_CYCLES (STABLE),
      .REPEAT_DELAY  (RDELAY),
      .REPEAT_PERIOD (RPER)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void add(input logic r, input logic [N-1:0] b, input logic [N-1:0] l,
                               input logic [N-1:0] t, input logic [N-1:0] rl, input int n);
      vec_t v;
      v.rst = r; v.btn = b; v.lvl = l; v.trg = t; v.rel = rl;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int idx,
                        input logic [N-1:0] l, input logic [N-1:0] t, input logic [N-1:0] rl);
      checks++;
      if (bus.level !== l || bus.trigger !== t || bus.released !== rl) begin
         failures++;
         $display("FAIL %s[%0d]: got level=%b trigger=%b released=%b, want level=%b trigger=%b released=%b",
                  name, idx, bus.level, bus.trigger, bus.released, l, t, rl);
      end
   endtask

   initial begin
      logic [N-1:0] el, et, er;
      bit           ar;
      bus.btn = '0;

      // reset held with all buttons pressed; fresh press after release
      add(1, 3'b111, 3'b000, 3'b000, 3'b000, 3);
      add(0, 3'b111, 3'b000, 3'b000, 3'b000, 5);
      add(0, 3'b111, 3'b111, 3'b111, 3'b000, 1);
      add(0, 3'b111, 3'b111, 3'b000, 3'b000, 1);
      add(0, 3'b000, 3'b111, 3'b000, 3'b000, 5);
      add(0, 3'b000, 3'b000, 3'b000, 3'b111, 1);
      add(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      // single press and release of btn[0]
      add(0, 3'b001, 3'b000, 3'b000, 3'b000, 5);
      add(0, 3'b001, 3'b001, 3'b001, 3'b000, 1);
      add(0, 3'b001, 3'b001, 3'b000, 3'b000, 2);
      add(0, 3'b000, 3'b001, 3'b000, 3'b000, 5);
      add(0, 3'b000, 3'b000, 3'b000, 3'b001, 1);
      add(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      // btn[1] glitch 3 high / 1 low / 3 high never reaches level
      add(0, 3'b010, 3'b000, 3'b000, 3'b000, 3);
      add(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      add(0, 3'b010, 3'b000, 3'b000, 3'b000, 3);
      add(0, 3'b000, 3'b000, 3'b000, 3'b000, 6);
      // btn[0] and btn[2] together
      add(0, 3'b101, 3'b000, 3'b000, 3'b000, 5);
      add(0, 3'b101, 3'b101, 3'b101, 3'b000, 1);
      add(0, 3'b101, 3'b101, 3'b000, 3'b000, 1);
      add(0, 3'b000, 3'b101, 3'b000, 3'b000, 5);
      add(0, 3'b000, 3'b000, 3'b000, 3'b101, 1);
      add(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      // reset mid-count discards progress, then full latency
      add(0, 3'b001, 3'b000, 3'b000, 3'b000, 2);
      add(1, 3'b001, 3'b000, 3'b000, 3'b000, 1);
      add(0, 3'b001, 3'b000, 3'b000, 3'b000, 5);
      add(0, 3'b001, 3'b001, 3'b001, 3'b000, 1);
      add(0, 3'b001, 3'b001, 3'b000, 3'b000, 1);
      add(0, 3'b000, 3'b001, 3'b000, 3'b000, 5);
      add(0, 3'b000, 3'b000, 3'b000, 3'b001, 1);
      add(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      // pulse of exactly STABLE cycles is accepted; release follows STABLE cycles later
      add(0, 3'b100, 3'b000, 3'b000, 3'b000, 4);
      add(0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
      add(0, 3'b000, 3'b100, 3'b100, 3'b000, 1);
      add(0, 3'b000, 3'b100, 3'b000, 3'b000, 3);
      add(0, 3'b000, 3'b000, 3'b000, 3'b100, 1);
      add(0, 3'b000, 3'b000, 3'b000, 3'b000, 2);

      foreach (vecs[i]) begin
         reset   = vecs[i].rst;
         bus.btn = vecs[i].btn;
         step();
         check("vec", i, vecs[i].lvl, vecs[i].trg, vecs[i].rel);
      end

      // long hold of btn[0]: one press strobe, plus repeats when built
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
      ar = 1'b1;
`else
      ar = 1'b0;
`endif
      for (int off = 0; off <= 70; off++) begin
         bus.btn = (off < 60) ? 3'b001 : 3'b000;
         step();
         el = (off >= 5 && off <= 64) ? 3'b001 : 3'b000;
         et = (off == 5 || (ar && off >= 5 + RDELAY && off <= 57 &&
                            (off - 5 - RDELAY) % RPER == 0)) ? 3'b001 : 3'b000;
         er = (off == 65) ? 3'b001 : 3'b000;
         check("hold", off, el, et, er);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/button_debouncer.md
# button_debouncer

Multi-input button debouncer. It sits between raw board push-buttons and control logic such as note key-on/key-off, sample select and tracker start/stop. Each input is synchronised to `clk` and must stay stable for a programmable number of cycles before its debounced level changes. It also produces single-cycle press (`trigger`) and release (`released`) strobes per button.

## Interface
Parameters:
- `BTN_COUNT`, default 7: number of independent button inputs, minimum 1.
- `STABLE_CYCLES`, default 500000: consecutive stable cycles required before a level change (10 ms at 50 MHz), minimum 1.
- `REPEAT_DELAY`, default 25000000: cycles from press to the first auto-repeat strobe. Used only with autorepeat.
- `REPEAT_PERIOD`, default 5000000: cycles between later auto-repeat strobes. Used only with autorepeat.

Ports (reset reset, synchronous, active-high; clock clk):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `btn` in BTN_COUNT: raw asynchronous inputs, active-high (1 = pressed). Inversion of active-low pins is done outside this block.
- `level` out BTN_COUNT: debounced, registered button state.
- `trigger` out BTN_COUNT: one-cycle pulse when `level` rises (press). Also carries auto-repeat pulses when that feature is built.
- `released` out BTN_COUNT: one-cycle pulse when `level` falls (release).

## Operation
- Each bit is processed independently and identically.
- Synchroniser: two flip-flops per bit, `btn` → `s1` → `s`.
- Per-bit counter, width `$clog2(STABLE_CYCLES+1)`. On every edge:
  - If `s == level`: counter is cleared to 0.
  - Else if counter `== STABLE_CYCLES-1`: `level <= s`, counter is cleared to 0.
  - Otherwise the counter increments.
- Any single cycle of agreement (a glitch back to the current level) restarts the count. Pulses shorter than `STABLE_CYCLES` never reach `level`.
- `trigger[i]` is 1 only in the cycle immediately after the edge where `level[i]` goes 0→1.
- `released[i]` is 1 only in the cycle immediately after the edge where `level[i]` goes 1→0.
- `trigger[i]` and `released[i]` are never both 1. Different bits may pulse in the same cycle.
- Reset:
  - Clears the synchroniser flops, counters, `level`, `trigger` and `released` to 0, plus the repeat state when autorepeat is built.
  - Reset applied mid-count discards the count.
  - A button held through reset release is reported as a fresh press after the normal latency.

## Timing
- Latency: if `btn[i]` changes just before edge E0 and is then held, `level[i]` and the matching strobe change at edge E0+STABLE_CYCLES+1. That is STABLE_CYCLES+2 edges counting E0.
- Strobe width: exactly one `clk` cycle.
- No handshake: outputs are free-running registers, valid every cycle.
- Minimum spacing between a press strobe and the following release strobe is STABLE_CYCLES cycles.

## Configuration
- Macro: `BUTTON_DEBOUNCER_AUTOREPEAT_EN`.
- When defined, each bit has a repeat counter:
  - The counter runs while `level[i]` is 1 and `s[i]` is 1, and clears when either is 0.
  - An extra `trigger[i]` pulse fires REPEAT_DELAY cycles after the press strobe.
  - Further pulses follow every REPEAT_PERIOD cycles until `level[i]` falls.
  - `released` is unaffected.
- When undefined, the repeat logic is absent. `REPEAT_DELAY` and `REPEAT_PERIOD` are accepted and ignored, and `trigger` pulses once per press.

## Structure
- Package `button_debouncer_pkg`: default constants `DEFAULT_STABLE_CYCLES`, `DEFAULT_REPEAT_DELAY`, `DEFAULT_REPEAT_PERIOD`, and a `cnt_width` helper function.
- Sub-module `debounce_channel`: one bit's synchroniser, stable counter, edge detector and optional repeat counter. It is instantiated BTN_COUNT times in a generate loop.

## Test plan
Bench settings are BTN_COUNT=3 and STABLE_CYCLES=4, plus REPEAT_DELAY=20 and REPEAT_PERIOD=8 for the autorepeat build.
- Reset held for 3 cycles with `btn`=3'b111 → all outputs 0 during reset. After release, `level`=3'b111 at edge 6 and `trigger`=3'b111 for exactly one cycle.
- `btn[0]` raised and held → `level[0]`=1 at edge 6 after the change and `trigger[0]` pulses once. Lowering it gives `released[0]` one cycle, 6 edges later.
- `btn[1]` glitch high for 3 cycles, low for 1, high for 3 → `level[1]` stays 0, no strobes.
- `btn[0]` and `btn[2]` raised together → both `trigger` bits pulse in the same cycle, and `btn[1]` outputs stay 0.
- Reset asserted while `btn[0]` has been high for 2 cycles → counter cleared and no strobe. After release, a press is reported after the full latency.
- Autorepeat build, `btn[0]` held for 60 cycles → `trigger[0]` pulses at press, press+20, press+28 and press+36, then continues every 8 cycles.
